// File: rtl/serial_cmd_tx.sv
// serial_cmd_tx: parallel-to-serial command transmitter.
// A word accepted on valid/ready is shifted out on sdata with a generated
// shift clock sclk, followed by a one-cycle slatch strobe.
// Optional build macro: SERIAL_CMD_TX_LSB_FIRST_EN (LSB-first, shift right).
// When the macro is not defined, bits go out MSB first with a left shift.
module serial_cmd_tx #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CLK_DIV    = 4
) (
   input  logic                  Clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  valid,
   output logic                  ready,
   output logic                  sdata,
   output logic                  sclk,
   output logic                  slatch
);

   localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t                state_q,   state_d;
   logic [DATA_WIDTH-1:0] shreg_q,   shreg_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]      div_q,     div_d;
   logic                  sdata_q,   sdata_d;
   logic                  sclk_q,    sclk_d;
   logic                  slatch_q,  slatch_d;
   logic                  ready_q,   ready_d;

   // State register and registered outputs; reset returns to an idle link.
   always_ff @(posedge Clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         div_q     <= '0;
         sdata_q   <= 1'b0;
         sclk_q    <= 1'b0;
         slatch_q  <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         div_q     <= div_d;
         sdata_q   <= sdata_d;
         sclk_q    <= sclk_d;
         slatch_q  <= slatch_d;
         ready_q   <= ready_d;
      end
   end

   // Next-state and next-output logic; outputs are precomputed so every
   // port comes straight from a flop.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      div_d     = div_q;
      sdata_d   = sdata_q;
      sclk_d    = sclk_q;
      slatch_d  = slatch_q;
      ready_d   = ready_q;

      case (state_q)
         IDLE: begin
            sdata_d  = 1'b0;
            sclk_d   = 1'b0;
            slatch_d = 1'b0;
            ready_d  = 1'b1;
            if (valid && ready_q) begin
               state_d   = SHIFT;
               shreg_d   = din;
               bit_cnt_d = '0;
               div_d     = '0;
               ready_d   = 1'b0;
`ifdef SERIAL_CMD_TX_LSB_FIRST_EN
               sdata_d   = din[0];
`else
               sdata_d   = din[DATA_WIDTH-1];
`endif
            end
         end

         SHIFT: begin
            if (div_q == DIV_LAST) begin
               // Bit boundary: sclk falls here, so sdata may change with it.
               div_d  = '0;
               sclk_d = 1'b0;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d  = LATCH;
                  sdata_d  = 1'b0;
                  slatch_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef SERIAL_CMD_TX_LSB_FIRST_EN
                  shreg_d   = shreg_q >> 1;
                  sdata_d   = shreg_d[0];
`else
                  shreg_d   = shreg_q << 1;
                  sdata_d   = shreg_d[DATA_WIDTH-1];
`endif
               end
            end else begin
               div_d  = div_q + DIV_W'(1);
               sclk_d = (div_d >= DIV_HALF);
            end
         end

         LATCH: begin
            state_d  = IDLE;
            sdata_d  = 1'b0;
            sclk_d   = 1'b0;
            slatch_d = 1'b0;
            ready_d  = 1'b1;
         end

         default: begin
            state_d  = IDLE;
            sdata_d  = 1'b0;
            sclk_d   = 1'b0;
            slatch_d = 1'b0;
            ready_d  = 1'b1;
         end
      endcase
   end

   assign ready  = ready_q;
   assign sdata  = sdata_q;
   assign sclk   = sclk_q;
   assign slatch = slatch_q;

endmodule

// File: tb/tb_serial_cmd_tx.sv
// Directed self-checking bench for serial_cmd_tx (DATA_WIDTH=8, CLK_DIV=4).
// Cycle c is the clock period following edge c-1; the accept edge is edge 0.
module tb_serial_cmd_tx;

   logic       Clk = 1'b0;
   logic       reset;
   logic [7:0] din;
   logic       valid;
   logic       ready;
   logic       sdata;
   logic       sclk;
   logic       slatch;

   always #5 Clk = ~Clk;

   serial_cmd_tx #(
      .DATA_WIDTH(8),
      .CLK_DIV   (4)
   ) dut (
      .Clk   (Clk),
      .reset (reset),
      .din   (din),
      .valid (valid),
      .ready (ready),
      .sdata (sdata),
      .sclk  (sclk),
      .slatch(slatch)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Observation state for one run window.
   logic [15:0] cap;
   int          nbits;
   int          latch_cnt;
   int          latch_at;
   int          ready_low;
   int          rise_at;
   int          fall_at;
   int          first_sclk_at;
   int          sdata_viol;
   logic        prev_sclk;
   logic        prev_sdata;
   logic        prev_ready;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic observe(input int c);
      if (sclk === 1'b1 && prev_sclk === 1'b0) begin
         cap = {cap[14:0], sdata};
         nbits++;
         if (first_sclk_at < 0) first_sclk_at = c;
      end
      if (sclk === 1'b1 && sdata !== prev_sdata) sdata_viol++;
      if (slatch === 1'b1) begin
         latch_cnt++;
         latch_at = c;
      end
      if (ready !== 1'b1) ready_low++;
      if (ready === 1'b1 && prev_ready !== 1'b1 && rise_at < 0) rise_at = c;
      if (ready !== 1'b1 && prev_ready === 1'b1 && rise_at >= 0 && fall_at < 0) fall_at = c;
      prev_sclk  = sclk;
      prev_sdata = sdata;
      prev_ready = ready;
   endtask

   // Present d0 with valid, accept on the next edge, then drive inputs per
   // cycle: valid high while c < valid_until, a din=0 valid pulse at
   // pulse_at, reset low for the edge at rst_at. Observes cycles 1..last.
   task automatic run_frame(input logic [7:0] d0, input logic [7:0] d1, input int valid_until,
                            input int pulse_at, input int rst_at, input int last);
      cap = '0; nbits = 0; latch_cnt = 0; latch_at = -1; ready_low = 0;
      rise_at = -1; fall_at = -1; first_sclk_at = -1; sdata_viol = 0;
      prev_sclk = sclk; prev_sdata = sdata; prev_ready = ready;
      din   = d0;
      valid = 1'b1;
      reset = 1'b1;
      @(posedge Clk); #1;
      observe(1);
      for (int c = 1; c < last; c++) begin
         valid = (c < valid_until) || (c == pulse_at);
         din   = (c == pulse_at) ? 8'h00 : d1;
         reset = (c == rst_at) ? 1'b0 : 1'b1;
         @(posedge Clk); #1;
         observe(c + 1);
         if (c == rst_at) begin
            check_val("mid_rst_ready",  {31'b0, ready},  32'd1);
            check_val("mid_rst_sdata",  {31'b0, sdata},  32'd0);
            check_val("mid_rst_sclk",   {31'b0, sclk},   32'd0);
            check_val("mid_rst_slatch", {31'b0, slatch}, 32'd0);
         end
      end
      valid = 1'b0;
      reset = 1'b1;
   endtask

   initial begin
      logic [7:0] exp_one;

      // Reset held with valid asserted: reset must win.
      reset = 1'b0;
      valid = 1'b1;
      din   = 8'hA5;
      repeat (2) @(posedge Clk);
      #1;
      check_val("rst_ready",  {31'b0, ready},  32'd1);
      check_val("rst_sdata",  {31'b0, sdata},  32'd0);
      check_val("rst_sclk",   {31'b0, sclk},   32'd0);
      check_val("rst_slatch", {31'b0, slatch}, 32'd0);
      reset = 1'b1;
      valid = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check_val("rst_no_xfer", {31'b0, ready}, 32'd1);

      // 0xA5 with a single-cycle valid.
      run_frame(8'hA5, 8'hA5, 1, -1, -1, 35);
      check_val("a5_byte",      {24'b0, cap[7:0]}, 32'hA5);
      check_val("a5_nbits",     nbits,             32'd8);
      check_val("a5_latch_cnt", latch_cnt,         32'd1);
      check_val("a5_latch_at",  latch_at,          32'd33);
      check_val("a5_ready_low", ready_low,         32'd33);
      check_val("a5_ready_up",  rise_at,           32'd34);
      check_val("a5_sclk_rise", first_sclk_at,     32'd3);
      check_val("a5_sdata_hi",  sdata_viol,        32'd0);

      // Valid pulse with din=0 while busy must be ignored.
      run_frame(8'h3C, 8'h3C, 1, 10, -1, 40);
      check_val("busy_byte",      {24'b0, cap[7:0]}, 32'h3C);
      check_val("busy_nbits",     nbits,             32'd8);
      check_val("busy_latch_cnt", latch_cnt,         32'd1);
      check_val("busy_ready_low", ready_low,         32'd33);

      // Back-to-back with valid held high.
      run_frame(8'h3C, 8'hC3, 35, -1, -1, 70);
      check_val("b2b_bytes",     {16'b0, cap},  32'h3CC3);
      check_val("b2b_nbits",     nbits,         32'd16);
      check_val("b2b_latch_cnt", latch_cnt,     32'd2);
      check_val("b2b_latch_at",  latch_at,      32'd67);
      check_val("b2b_ready_up",  rise_at,       32'd34);
      check_val("b2b_accept2",   fall_at,       32'd35);
      check_val("b2b_ready_low", ready_low,     32'd66);
      check_val("b2b_sdata_hi",  sdata_viol,    32'd0);

      // Reset for one edge at cycle 13 during 0xFF.
      run_frame(8'hFF, 8'hFF, 1, -1, 13, 40);
      check_val("abort_latch_cnt", latch_cnt, 32'd0);
      check_val("abort_nbits",     nbits,     32'd3);
      check_val("abort_ready_low", ready_low, 32'd13);

      run_frame(8'h81, 8'h81, 1, -1, -1, 35);
      check_val("post_byte",     {24'b0, cap[7:0]}, 32'h81);
      check_val("post_nbits",    nbits,             32'd8);
      check_val("post_latch_at", latch_at,          32'd33);

      // Bit order: 0x01 is the one vector here that is not bit-symmetric.
`ifdef SERIAL_CMD_TX_LSB_FIRST_EN
      exp_one = 8'h80;
`else
      exp_one = 8'h01;
`endif
      run_frame(8'h01, 8'h01, 1, -1, -1, 35);
      check_val("order_byte",      {24'b0, cap[7:0]}, {24'b0, exp_one});
      check_val("order_ready_low", ready_low,         32'd33);
      check_val("order_latch_at",  latch_at,          32'd33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_cmd_tx.md
# serial_cmd_tx

Parallel-to-serial command transmitter. It is the driving end of the board's serial command link, whose receive side is a chain of clocked D flip-flops. A byte is accepted with a valid/ready handshake, shifted out on a data line with a generated shift clock, and finished with a one-cycle latch strobe so the receiving chain can transfer its contents to its outputs. It sits between the main CPU command latch and the sound/IO board serial link.

## Interface
- DATA_WIDTH, 8, bits per transfer (≥ 2)
- CLK_DIV, 4, Clk cycles per serial bit; even, ≥ 2

- Clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-low reset
- din  input  DATA_WIDTH  word to transmit
- valid  input  1  din is presented for transmission
- ready  output  1  transmitter idle, can accept a word
- sdata  output  1  serial data to the receiver chain
- sclk  output  1  shift clock; the receiver samples sdata on the sclk rising edge
- slatch  output  1  one-cycle strobe after the last bit

## Operation
- All outputs are registered.
- Reset (reset low at a Clk edge): state IDLE, ready=1, sdata=0, sclk=0, slatch=0. Shift register, bit counter and divider counter are cleared.
- State machine:
  - IDLE → SHIFT on valid&&ready at an edge. din is captured into the shift register. Bit counter=0, divider=0, ready=0. sdata is driven with the first bit.
  - SHIFT: the divider counts 0..CLK_DIV-1. sclk=1 while divider ≥ CLK_DIV/2, otherwise 0. When divider wraps from CLK_DIV-1 to 0, the register shifts, sdata takes the next bit and the bit counter increments. sdata changes only while sclk=0.
  - SHIFT → LATCH when the divider reaches CLK_DIV-1 and the bit counter reaches DATA_WIDTH-1. In LATCH: sclk=0, slatch=1, sdata=0.
  - LATCH → IDLE unconditionally on the next edge: slatch=0, ready=1.
- Bit order is MSB first (default build).
- valid while ready=0 is ignored. Changes on din after capture have no effect.
- Reset mid-transfer aborts the transfer at that edge: no slatch pulse, and no partial word is re-sent.
- reset has priority over valid on the same edge.

## Timing
- Accept edge = cycle 0.
- Bit k occupies cycles k·CLK_DIV+1 … (k+1)·CLK_DIV:
  - sclk low for the first CLK_DIV/2 cycles of the bit, high for the last CLK_DIV/2.
  - The sclk rising edge is at cycle k·CLK_DIV+1+CLK_DIV/2.
- slatch is high during cycle DATA_WIDTH·CLK_DIV+1.
- ready is low for DATA_WIDTH·CLK_DIV+1 cycles, which is 33 for the defaults. It returns high in cycle DATA_WIDTH·CLK_DIV+2.
- Back-to-back transfers: with valid held high, the next word is accepted on the first edge where ready=1. The gap between transfers is 1 LATCH cycle plus 1 IDLE cycle.
- No combinational path from any input to any output.

## Configuration
- SERIAL_CMD_TX_LSB_FIRST_EN defined: bits are sent LSB first and the shift register shifts right.
- Not defined: bits are sent MSB first and the shift register shifts left.
- The macro does not change handshake, timing or strobe behaviour.

## Test plan
- Reset: hold reset=0 for 2 edges with valid=1 → ready=1, sdata=sclk=slatch=0, no transfer starts.
- Defaults, din=0xA5, one-cycle valid:
  - sdata sampled at the 8 sclk rising edges = 1,0,1,0,0,1,0,1.
  - slatch high only in cycle 33.
  - ready low in cycles 1–33, high in cycle 34.
- Busy ignore: send 0x3C, then pulse valid with din=0x00 at cycle 10 → the stream is still 0x3C, exactly one slatch, and no second transfer.
- Back-to-back: valid held high, din=0x3C then 0xC3 on acceptance → two complete frames, second accept edge at cycle 34, decoded bytes 0x3C and 0xC3.
- Reset mid-operation: reset low for one edge at cycle 13 during 0xFF → outputs return to idle at that edge, slatch never asserts, and a following 0x81 transfers intact.
- With SERIAL_CMD_TX_LSB_FIRST_EN, din=0x01 → stream 1,0,0,0,0,0,0,0; same 33-cycle ready-low window.
